// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement,
// dirty-victim writeback and word-serial full-line refill over a req/ack memory port.
module cache_nway_wb #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADR_WIDTH  = 32,
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned SETS       = 128,
    parameter int unsigned WORD_NUM   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic [ADR_WIDTH-1:0]  cpu_adr_i,
    input  logic [WORD_WIDTH-1:0] cpu_dat_i,
    input  logic                  cpu_rdwr_i,
    output logic                  cpu_ack_o,
    output logic [WORD_WIDTH-1:0] cpu_dat_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADR_WIDTH-1:0]  mem_adr_o,
    output logic [WORD_WIDTH-1:0] mem_dat_o,
    input  logic                  mem_ack_i,
    input  logic [WORD_WIDTH-1:0] mem_dat_i
);
    localparam int unsigned BOFF = $clog2(WORD_WIDTH / 8);
    localparam int unsigned WOFF = $clog2(WORD_NUM);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAG  = ADR_WIDTH - IDX - WOFF - BOFF;
    localparam int unsigned WAYB = $clog2(WAY_NUM);
    localparam int unsigned RADR = ADR_WIDTH - BOFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [RADR-1:0]       req_adr_q;
    logic [WORD_WIDTH-1:0] req_dat_q;
    logic                  req_wr_q;
    logic [WAYB-1:0]       victim_q, victim_d;
    logic [WOFF-1:0]       cnt_q, cnt_d, cnt_nx;

    logic [TAG-1:0]        tag_mem  [WAY_NUM][SETS];
    logic [WORD_WIDTH-1:0] data_mem [WAY_NUM][SETS][WORD_NUM];
    logic                  valid_q  [WAY_NUM][SETS];
    logic                  dirty_q  [WAY_NUM][SETS];
    logic [WAYB-1:0]       age_q    [WAY_NUM][SETS];

    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [WOFF-1:0]       req_word;
    logic                  hit, mem_beat;
    logic [WAYB-1:0]       hit_way, vic_way, touch_way, touch_age, data_way;
    logic                  ack_d, mem_req_d, mem_we_d, latch;
    logic [WORD_WIDTH-1:0] cpu_dat_d, mem_dat_d, data_wdata;
    logic [ADR_WIDTH-1:0]  mem_adr_d;
    logic                  data_we, touch, fill, dirty_set, valid_clr;
    logic [WOFF-1:0]       data_word;
    logic                  unused_boff;

    assign req_tag     = req_adr_q[RADR-1 -: TAG];
    assign req_idx     = req_adr_q[WOFF +: IDX];
    assign req_word    = req_adr_q[WOFF-1:0];
    assign cnt_nx      = cnt_q + WOFF'(1);
    assign mem_beat    = mem_req_o & mem_ack_i;
    assign touch_age   = age_q[touch_way][req_idx];
    assign unused_boff = ^cpu_adr_i[BOFF-1:0];

    function automatic logic [ADR_WIDTH-1:0] mk_adr(input logic [TAG-1:0] t,
                                                     input logic [IDX-1:0] i,
                                                     input logic [WOFF-1:0] w);
        mk_adr = ADR_WIDTH'({t, i, w}) << BOFF;
    endfunction

    // Hit detection (lowest way wins) and victim choice (lowest invalid, else oldest)
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = '0;
        for (int w = int'(WAY_NUM) - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAYB'(w);
            end
            if (age_q[w][req_idx] == WAYB'(WAY_NUM - 1))
                vic_way = WAYB'(w);
        end
        for (int w = int'(WAY_NUM) - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx])
                vic_way = WAYB'(w);
        end
    end

    // Next-state, next-output and array update decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        ack_d      = 1'b0;
        cpu_dat_d  = cpu_dat_o;
        mem_req_d  = mem_req_o;
        mem_we_d   = mem_we_o;
        mem_adr_d  = mem_adr_o;
        mem_dat_d  = mem_dat_o;
        latch      = 1'b0;
        data_we    = 1'b0;
        data_way   = hit_way;
        data_word  = req_word;
        data_wdata = req_dat_q;
        touch      = 1'b0;
        touch_way  = hit_way;
        fill       = 1'b0;
        dirty_set  = 1'b0;
        valid_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    latch   = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    touch   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                    if (req_wr_q) begin
                        data_we   = 1'b1;
                        dirty_set = 1'b1;
                    end else begin
                        cpu_dat_d = data_mem[hit_way][req_idx][req_word];
                    end
                end else begin
                    victim_d  = vic_way;
                    cnt_d     = '0;
                    valid_clr = 1'b1;
                    mem_req_d = 1'b1;
                    if (valid_q[vic_way][req_idx] && dirty_q[vic_way][req_idx]) begin
                        state_d   = WRITEBACK;
                        mem_we_d  = 1'b1;
                        mem_adr_d = mk_adr(tag_mem[vic_way][req_idx], req_idx, '0);
                        mem_dat_d = data_mem[vic_way][req_idx][0];
                    end else begin
                        state_d   = REFILL;
                        mem_we_d  = 1'b0;
                        mem_adr_d = mk_adr(req_tag, req_idx, '0);
                    end
                end
            end
            WRITEBACK: begin
                if (mem_beat) begin
                    if (cnt_q == WOFF'(WORD_NUM - 1)) begin
                        state_d   = REFILL;
                        cnt_d     = '0;
                        mem_we_d  = 1'b0;
                        mem_adr_d = mk_adr(req_tag, req_idx, '0);
                    end else begin
                        cnt_d     = cnt_nx;
                        mem_adr_d = mk_adr(tag_mem[victim_q][req_idx], req_idx, cnt_nx);
                        mem_dat_d = data_mem[victim_q][req_idx][cnt_nx];
                    end
                end
            end
            REFILL: begin
                if (mem_beat) begin
                    data_we    = 1'b1;
                    data_way   = victim_q;
                    data_word  = cnt_q;
                    data_wdata = (req_wr_q && cnt_q == req_word) ? req_dat_q : mem_dat_i;
                    if (cnt_q == WOFF'(WORD_NUM - 1)) begin
                        fill      = 1'b1;
                        touch     = 1'b1;
                        touch_way = victim_q;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = RESPOND;
                    end else begin
                        cnt_d     = cnt_nx;
                        mem_adr_d = mk_adr(req_tag, req_idx, cnt_nx);
                    end
                end
            end
            RESPOND: begin
                ack_d   = 1'b1;
                state_d = IDLE;
                if (!req_wr_q)
                    cpu_dat_d = data_mem[victim_q][req_idx][req_word];
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            victim_q  <= '0;
            req_adr_q <= '0;
            req_dat_q <= '0;
            req_wr_q  <= 1'b0;
            cpu_ack_o <= 1'b0;
            cpu_dat_o <= '0;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            victim_q  <= victim_d;
            cpu_ack_o <= ack_d;
            cpu_dat_o <= cpu_dat_d;
            mem_req_o <= mem_req_d;
            mem_we_o  <= mem_we_d;
            mem_adr_o <= mem_adr_d;
            mem_dat_o <= mem_dat_d;
            if (latch) begin
                req_adr_q <= cpu_adr_i[ADR_WIDTH-1:BOFF];
                req_dat_q <= cpu_dat_i;
                req_wr_q  <= cpu_rdwr_i;
            end
        end
    end

    // Line metadata: valid/dirty bits and per-set LRU ages
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < int'(WAY_NUM); w++) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAYB'(w);
                end
            end
        end else begin
            if (valid_clr) begin
                valid_q[vic_way][req_idx] <= 1'b0;
                dirty_q[vic_way][req_idx] <= 1'b0;
            end
            if (dirty_set)
                dirty_q[hit_way][req_idx] <= 1'b1;
            if (fill) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= req_wr_q;
            end
            if (touch) begin
                for (int w = 0; w < int'(WAY_NUM); w++) begin
                    if (age_q[w][req_idx] < touch_age)
                        age_q[w][req_idx] <= age_q[w][req_idx] + WAYB'(1);
                end
                age_q[touch_way][req_idx] <= '0;
            end
        end
    end

    // Tag and data storage, no reset needed
    always_ff @(posedge clk) begin
        if (data_we)
            data_mem[data_way][req_idx][data_word] <= data_wdata;
        if (fill)
            tag_mem[victim_q][req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Self-checking bench for cache_nway_wb: flat golden memory plus an MRU-ordered tag list
// per set predict read data and the exact memory beat sequence of every access.
`timescale 1ns/1ps
module tb_cache_nway_wb;
    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned ADR_WIDTH  = 32;
    localparam int unsigned WAY_NUM    = 4;
    localparam int unsigned SETS       = 128;
    localparam int unsigned WORD_NUM   = 4;
    localparam int unsigned BOFF       = $clog2(WORD_WIDTH / 8);
    localparam int unsigned WOFF       = $clog2(WORD_NUM);
    localparam int unsigned IDXB       = $clog2(SETS);
    localparam int unsigned LINE_BYTES = WORD_NUM * (WORD_WIDTH / 8);

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } tx_t;

    logic        clk, rst;
    logic        cpu_req_i, cpu_rdwr_i, cpu_ack_o;
    logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;

    cache_nway_wb #(.WORD_WIDTH(WORD_WIDTH), .ADR_WIDTH(ADR_WIDTH), .WAY_NUM(WAY_NUM),
                    .SETS(SETS), .WORD_NUM(WORD_NUM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
        .cpu_rdwr_i(cpu_rdwr_i), .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  backing [logic [31:0]];
    logic [31:0]  gold    [logic [31:0]];
    bit           dirty_m [logic [31:0]];
    int unsigned  lru_q   [SETS][$];
    tx_t          txq[$];
    int           wait_cnt;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    // Word-serial memory with random response latency; logs every accepted beat
    initial begin
        mem_ack_i = 1'b0;
        mem_dat_i = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_req_o && rst) begin
                if (wait_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        backing[mem_adr_o] = mem_dat_o;
                    end else begin
                        mem_dat_i = backing.exists(mem_adr_o) ? backing[mem_adr_o]
                                                              : init_word(mem_adr_o);
                    end
                    txq.push_back('{mem_we_o, mem_adr_o, mem_dat_o});
                    wait_cnt = int'($urandom_range(0, 2));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++) lru_q[s].delete();
        dirty_m.delete();
        gold = backing;
        txq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One CPU transaction, predicted and checked against the model
    task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic [31:0] rd);
        tx_t         expq[$];
        logic [31:0] al, base, vbase;
        int unsigned s, t, vt;
        int          pos, lat;
        bit          got, exp_hit;
        al   = {adr[31:2], 2'b00};
        base = al & ~(LINE_BYTES - 1);
        s    = (al >> (BOFF + WOFF)) % SETS;
        t    = al >> (BOFF + WOFF + IDXB);
        pos  = -1;
        for (int i = 0; i < lru_q[s].size(); i++)
            if (lru_q[s][i] == t) pos = i;
        exp_hit = (pos >= 0);
        if (exp_hit) begin
            lru_q[s].delete(pos);
        end else begin
            if (lru_q[s].size() == WAY_NUM) begin
                vt    = lru_q[s].pop_back();
                vbase = (vt << (BOFF + WOFF + IDXB)) | (s << (BOFF + WOFF));
                if (dirty_m.exists(vbase) && dirty_m[vbase])
                    for (int k = 0; k < int'(WORD_NUM); k++)
                        expq.push_back('{1'b1, vbase + 32'(4 * k), 32'h0});
                dirty_m.delete(vbase);
            end
            for (int k = 0; k < int'(WORD_NUM); k++)
                expq.push_back('{1'b0, base + 32'(4 * k), 32'h0});
            dirty_m[base] = 1'b0;
        end
        lru_q[s].push_front(t);
        if (we) dirty_m[base] = 1'b1;

        @(negedge clk);
        txq.delete();
        cpu_req_i  = 1'b1;
        cpu_rdwr_i = we;
        cpu_adr_i  = adr;
        cpu_dat_i  = dat;
        lat = 0;
        got = 1'b0;
        rd  = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            lat++;
            if (cpu_ack_o) begin
                got = 1'b1;
                rd  = cpu_dat_o;
                break;
            end
            cpu_adr_i  = $urandom;
            cpu_dat_i  = $urandom;
            cpu_rdwr_i = ~we;
        end
        cpu_req_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: adr %h no ack within 500 cycles", adr);
            return;
        end
        @(negedge clk);
        checks++;
        if (cpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack still %b one cycle later, expected 0", cpu_ack_o);
        end
        if (exp_hit) begin
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL hit_latency: adr %h latency %0d expected 2", adr, lat);
            end
        end
        checks++;
        if (txq.size() !== expq.size()) begin
            errors++;
            $display("FAIL beat_count: adr %h got %0d beats expected %0d", adr, txq.size(), expq.size());
        end
        for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
            checks++;
            if (txq[i].we !== expq[i].we || txq[i].adr !== expq[i].adr) begin
                errors++;
                $display("FAIL beat_%0d: got we=%b adr=%h expected we=%b adr=%h",
                         i, txq[i].we, txq[i].adr, expq[i].we, expq[i].adr);
            end else if (txq[i].we) begin
                checks++;
                if (txq[i].dat !== gold_word(txq[i].adr)) begin
                    errors++;
                    $display("FAIL wb_data: adr %h got %h expected %h",
                             txq[i].adr, txq[i].dat, gold_word(txq[i].adr));
                end
            end
        end
        if (!we) begin
            checks++;
            if (rd !== gold_word(al)) begin
                errors++;
                $display("FAIL read_data: adr %h got %h expected %h", adr, rd, gold_word(al));
            end
        end else begin
            gold[al] = dat;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_ack_o, cpu_dat_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b cdat=%h req=%b we=%b madr=%h mdat=%h expected all 0",
                     cpu_ack_o, cpu_dat_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o);
        end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd, rd2;
        do_reset();
        access(1'b0, 32'h1008, 32'h0, rd);
        checks++;
        if (txq.size() < 4 || txq[0].adr !== 32'h1000 || txq[3].adr !== 32'h100C) begin
            errors++;
            $display("FAIL cold_read_addrs: %0d beats, expected 0x1000..0x100C", txq.size());
        end
        access(1'b0, 32'h1008, 32'h0, rd2);
        checks++;
        if (rd2 !== rd) begin
            errors++;
            $display("FAIL reread: got %h expected %h", rd2, rd);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd;
        access(1'b1, 32'h3008, 32'h12345678, rd);
        access(1'b0, 32'h3008, 32'h0, rd);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL write_miss_read: got %h expected 12345678", rd);
        end
    endtask

    task automatic test_lru_clean();
        logic [31:0] rd;
        do_reset();
        access(1'b0, 32'h0000, 32'h0, rd);
        access(1'b0, 32'h0800, 32'h0, rd);
        access(1'b0, 32'h1000, 32'h0, rd);
        access(1'b0, 32'h1800, 32'h0, rd);
        access(1'b0, 32'h0000, 32'h0, rd);
        access(1'b0, 32'h2000, 32'h0, rd);
        checks++;
        if (txq.size() !== 4 || txq[0].we !== 1'b0) begin
            errors++;
            $display("FAIL clean_evict: %0d beats, expected 4 reads only", txq.size());
        end
        access(1'b0, 32'h0000, 32'h0, rd);
        access(1'b0, 32'h0800, 32'h0, rd);
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd;
        do_reset();
        access(1'b0, 32'h0000, 32'h0, rd);
        access(1'b0, 32'h0800, 32'h0, rd);
        access(1'b0, 32'h1000, 32'h0, rd);
        access(1'b0, 32'h1800, 32'h0, rd);
        access(1'b1, 32'h0004, 32'hDEADBEEF, rd);
        access(1'b0, 32'h0800, 32'h0, rd);
        access(1'b0, 32'h1000, 32'h0, rd);
        access(1'b0, 32'h1800, 32'h0, rd);
        access(1'b0, 32'h2000, 32'h0, rd);
        checks++;
        if (txq.size() !== 8 || txq[1].we !== 1'b1 || txq[1].adr !== 32'h0004 ||
            txq[1].dat !== 32'hDEADBEEF || txq[4].adr !== 32'h2000) begin
            errors++;
            $display("FAIL dirty_evict: %0d beats, expected 4 writes (2nd DEADBEEF) then reads at 0x2000",
                     txq.size());
        end
        access(1'b0, 32'h0004, 32'h0, rd);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        bit          seen;
        do_reset();
        @(negedge clk);
        txq.delete();
        cpu_req_i  = 1'b1;
        cpu_rdwr_i = 1'b0;
        cpu_adr_i  = 32'h5008;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (txq.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        rst       = 1'b0;
        cpu_req_i = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_setup: only %0d refill beats seen, expected 2", txq.size());
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_ack_o, cpu_dat_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: req=%b we=%b madr=%h ack=%b, expected all 0",
                     mem_req_o, mem_we_o, mem_adr_o, cpu_ack_o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        access(1'b0, 32'h5008, 32'h0, rd);
        checks++;
        if (txq.size() !== 4) begin
            errors++;
            $display("FAIL abort_refill: %0d beats, expected full 4-word refill", txq.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, adr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            adr = (32'($urandom_range(0, 5)) << (BOFF + WOFF + IDXB)) |
                  (32'($urandom_range(0, 2)) << (BOFF + WOFF)) |
                  (32'($urandom_range(0, WORD_NUM - 1)) << BOFF) |
                  32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), adr, $urandom, rd);
        end
    endtask

    initial begin
        rst        = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_rdwr_i = 1'b0;
        cpu_adr_i  = '0;
        cpu_dat_i  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_cold_read();
        test_write_miss();
        test_lru_clean();
        test_dirty_evict();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
